// File: rtl/rr_merge8_if.sv
// Handshake bundle between two byte producers, the round-robin merge stage
// and its downstream consumer. The master side drives producer data/valids
// and the consumer ready; the slave side is the merge stage itself.
interface rr_merge8_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b;
  logic             b_valid;
  logic             b_ready;
  logic             s;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             y_src;

  modport master (
    output a, a_valid, b, b_valid, y_ready,
    input  a_ready, b_ready, s, y, y_valid, y_src
  );

  modport slave (
    input  a, a_valid, b, b_valid, y_ready,
    output a_ready, b_ready, s, y, y_valid, y_src
  );
endinterface

// File: rtl/rr_merge8.sv
// Two-input round-robin merge with a one-entry registered output buffer.
// The grant select s also steers the downstream 2:1 byte mux. A full buffer
// can drain and refill in the same cycle, so throughput is one byte per clock.
module rr_merge8 #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_merge8_if.slave   io
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             prio_q;
  logic [WIDTH-1:0] y_p1;
  logic             src_p1;

  logic             can_take;
  logic             grant_a;
  logic             grant_b;
  logic             sel;
  logic             xfer;
  logic [WIDTH-1:0] win_data;

  // Byte chosen by the grant; the same select drives the external mux.
  function automatic logic [WIDTH-1:0] pick(input logic s_in,
                                            input logic [WIDTH-1:0] d_a,
                                            input logic [WIDTH-1:0] d_b);
    return s_in ? d_b : d_a;
  endfunction

  // Arbitration: a lone requester always wins, a tie goes to the side prio
  // names, and with no requester the select simply parks on prio.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    sel      = prio_q;
    if (io.a_valid && io.b_valid) begin
      grant_a = ~prio_q;
      grant_b = prio_q;
      sel     = prio_q;
    end else if (io.a_valid) begin
      grant_a = 1'b1;
      sel     = 1'b0;
    end else if (io.b_valid) begin
      grant_b = 1'b1;
      sel     = 1'b1;
    end
    // rst gates the readies so nothing is accepted while reset is held.
    can_take = ((state_q == EMPTY) || io.y_ready) && !rst;
    xfer     = can_take && (grant_a || grant_b);
    win_data = pick(sel, io.a, io.b);
  end

  assign io.a_ready = can_take & grant_a;
  assign io.b_ready = can_take & grant_b;
  assign io.s       = sel;
  assign io.y       = y_p1;
  assign io.y_src   = src_p1;
  assign io.y_valid = (state_q == FULL);

  // Buffer occupancy: fill on any transfer, empty when drained with no refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (io.y_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy state and round-robin pointer; the pointer turns away from
  // whichever side won the last transfer, even an uncontested one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) prio_q <= ~sel;
    end
  end

  // ---- stage p1: output buffer, held bit-stable while not refilled ----
  // Reset clears the byte too, so a value stuck under backpressure is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p1   <= '0;
      src_p1 <= 1'b0;
    end else if (xfer) begin
      y_p1   <= win_data;
      src_p1 <= sel;
    end
  end

endmodule

// File: tb/tb_rr_merge8.sv
// Bench for rr_merge8: directed scenarios with literal expectations, then a
// long randomized run. A behavioural model (buffer contents, occupancy flag,
// last winner) predicts every output and is compared on each falling edge.
module tb_rr_merge8;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   started;

  rr_merge8_if #(.WIDTH(W)) bus ();

  rr_merge8 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [W-1:0] m_y;
  logic         m_full;
  logic         m_src;
  logic         m_last;   // last winner; 1 means B won last, so A is favoured

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Winner by rule: lone requester wins, tie goes away from the last winner.
  function automatic logic winner(input logic av, input logic bv, input logic last);
    if (av && bv) return ~last;
    if (av) return 1'b0;
    return 1'b1;
  endfunction

  // Model update at every rising edge using the inputs held through the cycle.
  always @(posedge clk) begin
    logic w;
    logic take;
    started = 1'b1;
    if (rst) begin
      m_y = '0; m_full = 1'b0; m_src = 1'b0; m_last = 1'b1;
    end else begin
      take = !m_full || bus.y_ready;
      if (take && (bus.a_valid || bus.b_valid)) begin
        w      = winner(bus.a_valid, bus.b_valid, m_last);
        m_y    = w ? bus.b : bus.a;
        m_src  = w;
        m_full = 1'b1;
        m_last = w;
      end else if (bus.y_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic any, w, ea, eb;
    if (started) begin
      any = bus.a_valid || bus.b_valid;
      w   = winner(bus.a_valid, bus.b_valid, m_last);
      ea  = !rst && (!m_full || bus.y_ready) && any && !w;
      eb  = !rst && (!m_full || bus.y_ready) && any && w;
      chk("a_ready", bus.a_ready, ea);
      chk("b_ready", bus.b_ready, eb);
      if (ea || eb) chk("s", bus.s, w);
      chk("y_valid", bus.y_valid, m_full);
      chk("y", bus.y, m_y);
      chk("y_src", bus.y_src, m_src);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd, input logic yr);
    bus.a_valid = av; bus.a = ad; bus.b_valid = bv; bus.b = bd; bus.y_ready = yr;
  endtask

  logic [W-1:0] exp3 [6];
  logic         src3 [6];
  logic         acc_a, acc_b, was_rst;

  initial begin
    checks = 0; errors = 0; started = 1'b0;
    exp3 = '{8'h80, 8'h01, 8'h80, 8'h01, 8'h80, 8'h01};
    src3 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // 1. reset with both producers requesting
    rst = 1'b1;
    drive(1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
    cyc(); cyc();
    chk("rst_y_valid", bus.y_valid, 1'b0);
    chk("rst_y", bus.y, 8'h00);
    chk("rst_y_src", bus.y_src, 1'b0);
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_b_ready", bus.b_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("first_grant_a_ready", bus.a_ready, 1'b1);
    chk("first_grant_s", bus.s, 1'b0);

    // 2. single source A, then single source B
    drive(1'b1, 8'hF0, 1'b0, 8'h00, 1'b1);
    #1 chk("single_a_ready", bus.a_ready, 1'b1);
    cyc();
    chk("single_a_y", bus.y, 8'hF0);
    chk("single_a_src", bus.y_src, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 8'h0F, 1'b1);
    cyc();
    chk("single_b_y", bus.y, 8'h0F);
    chk("single_b_src", bus.y_src, 1'b1);

    // 3. tie alternation (B won last, so A goes first)
    drive(1'b1, 8'h80, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("tie_y", bus.y, exp3[i]);
      chk("tie_src", bus.y_src, src3[i]);
      chk("tie_y_valid", bus.y_valid, 1'b1);
    end

    // 4. backpressure
    drive(1'b1, 8'hAA, 1'b0, 8'h00, 1'b1);
    cyc();
    drive(1'b0, 8'h00, 1'b1, 8'h5C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_y", bus.y, 8'hAA);
      chk("bp_b_ready", bus.b_ready, 1'b0);
    end
    bus.y_ready = 1'b1;
    #1 chk("bp_release_b_ready", bus.b_ready, 1'b1);
    cyc();
    chk("bp_release_y", bus.y, 8'h5C);
    chk("bp_release_valid", bus.y_valid, 1'b1);

    // 5. last-winner rotation
    drive(1'b0, 8'h00, 1'b1, 8'h11, 1'b1);
    cyc();
    drive(1'b1, 8'h22, 1'b1, 8'h33, 1'b1);
    #1 chk("rot_after_b_s", bus.s, 1'b0);
    cyc();
    chk("rot_after_b_y", bus.y, 8'h22);
    drive(1'b1, 8'h44, 1'b0, 8'h00, 1'b1);
    cyc();
    drive(1'b1, 8'h22, 1'b1, 8'h33, 1'b1);
    #1 chk("rot_after_a_s", bus.s, 1'b1);
    cyc();
    chk("rot_after_a_y", bus.y, 8'h33);

    // 6. reset in the middle of backpressure (A won last, pointer favours B)
    drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("mid_hold_y", bus.y, 8'h55);
    chk("mid_hold_valid", bus.y_valid, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_valid", bus.y_valid, 1'b0);
    chk("mid_rst_y", bus.y, 8'h00);
    drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
    #1 chk("mid_rst_s", bus.s, 1'b0);
    chk("mid_rst_a_ready", bus.a_ready, 1'b1);
    cyc();

    // Randomized run; producers hold data until accepted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc_a   = bus.a_valid && bus.a_ready;
      acc_b   = bus.b_valid && bus.b_ready;
      was_rst = rst;
      @(posedge clk);
      #1;
      if (!bus.a_valid || acc_a || was_rst) begin
        bus.a_valid = ($urandom_range(0, 3) != 0);
        bus.a       = W'($urandom);
      end
      if (!bus.b_valid || acc_b || was_rst) begin
        bus.b_valid = ($urandom_range(0, 3) != 0);
        bus.b       = W'($urandom);
      end
      bus.y_ready = ($urandom_range(0, 2) != 0);
      rst         = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    cyc();
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
